// File: rtl/arith_engine_pkg.sv
// Shared opcode encodings, flag bit positions and helpers for arith_engine.
package arith_engine_pkg;

  typedef enum logic [2:0] {
    OP_OR   = 3'b000,
    OP_NAND = 3'b001,
    OP_NOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101
  } op_e;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_N    = 3;
  localparam int unsigned FLAG_Z    = 2;
  localparam int unsigned FLAG_C    = 1;
  localparam int unsigned FLAG_V    = 0;

  // Two's-complement overflow: operands agree in sign and the result does not.
  function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Subtraction overflows when operand signs differ and the result flips from a.
  function automatic logic sub_overflow(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/arith_engine_alu.sv
// Combinational ALU core: six logic/arithmetic ops, reserved-opcode detection,
// and {N,Z,C,V} flags when ARITH_ENGINE_FLAGS_EN is defined (otherwise flags = 0).
module arith_engine_alu
  import arith_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  output logic [WIDTH-1:0]     result,
  output logic                 illegal,
  output logic [NUM_FLAGS-1:0] flags
);

  op_e opc;
  assign opc = op_e'(op);

  // Unlisted and unknown opcodes fall into default and read as reserved.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opc)
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_AND:  result = a & b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      default: illegal = 1'b1;
    endcase
  end

`ifdef ARITH_ENGINE_FLAGS_EN
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;

  // Extended-width forms expose carry-out and borrow (a < b) in the top bit.
  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    case (opc)
      OP_ADD: begin
        flags[FLAG_C] = add_ext[WIDTH];
        flags[FLAG_V] = add_overflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1]);
      end
      OP_SUB: begin
        flags[FLAG_C] = sub_ext[WIDTH];
        flags[FLAG_V] = sub_overflow(a[WIDTH-1], b[WIDTH-1], result[WIDTH-1]);
      end
      default: ;
    endcase
  end
`else
  assign flags = '0;
`endif

endmodule

// File: rtl/arith_engine.sv
// Registered ALU: one-cycle latency result, valid, illegal and flag outputs.
// Status flags are produced only when ARITH_ENGINE_FLAGS_EN is defined.
module arith_engine
  import arith_engine_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [2:0]       i_instruction,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] out,
  output logic             o_valid,
  output logic             o_illegal,
  output logic [3:0]       o_flags
);

  logic [WIDTH-1:0]     alu_result;
  logic                 alu_illegal;
  logic [NUM_FLAGS-1:0] alu_flags;

  arith_engine_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a      (i_a),
    .b      (i_b),
    .op     (i_instruction),
    .result (alu_result),
    .illegal(alu_illegal),
    .flags  (alu_flags)
  );

  // Reset wins over a coincident request; idle cycles hold the last result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      out       <= '0;
      o_valid   <= 1'b0;
      o_illegal <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        out       <= alu_result;
        o_illegal <= alu_illegal;
      end
    end
  end

`ifdef ARITH_ENGINE_FLAGS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_flags <= '0;
    end else if (i_valid) begin
      o_flags <= alu_flags;
    end
  end
`else
  assign o_flags = alu_flags;
`endif

endmodule

// File: tb/tb_arith_engine.sv
// Self-checking bench for arith_engine: vector table plus reset/hold/stream sequences.
module tb_arith_engine;

`ifdef ARITH_ENGINE_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic [2:0] i_instruction;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [7:0] out;
  logic       o_valid;
  logic       o_illegal;
  logic [3:0] o_flags;

  int checks = 0;
  int errors = 0;

  arith_engine #(
    .WIDTH(8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_instruction(i_instruction),
    .i_a          (i_a),
    .i_b          (i_b),
    .out          (out),
    .o_valid      (o_valid),
    .o_illegal    (o_illegal),
    .o_flags      (o_flags)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_ill;
    logic [3:0] exp_flags;  // {N,Z,C,V}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] fexp(input logic [3:0] f);
    return FLAGS_ON ? f : 4'h0;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    i_valid       = v;
    i_instruction = op;
    i_a           = a;
    i_b           = b;
  endtask

  task automatic check_all(input string name, input logic [7:0] eo, input logic ev,
                           input logic ei, input logic [3:0] ef);
    check({name, ".out"}, 32'(out), 32'(eo));
    check({name, ".valid"}, 32'(o_valid), 32'(ev));
    check({name, ".illegal"}, 32'(o_illegal), 32'(ei));
    check({name, ".flags"}, 32'(o_flags), 32'(fexp(ef)));
  endtask

  initial begin
    vecs.push_back('{"or_aa_55",    3'b000, 8'hAA, 8'h55, 8'hFF, 1'b0, 4'b1000});
    vecs.push_back('{"nand_12_23",  3'b001, 8'h12, 8'h23, 8'hFD, 1'b0, 4'b1000});
    vecs.push_back('{"and_ff_01",   3'b011, 8'hFF, 8'h01, 8'h01, 1'b0, 4'b0000});
    vecs.push_back('{"nor_80_c4",   3'b010, 8'h80, 8'hC4, 8'h3B, 1'b0, 4'b0000});
    vecs.push_back('{"nand_ff_ff",  3'b001, 8'hFF, 8'hFF, 8'h00, 1'b0, 4'b0100});
    vecs.push_back('{"nor_00_00",   3'b010, 8'h00, 8'h00, 8'hFF, 1'b0, 4'b1000});
    vecs.push_back('{"add_55_55",   3'b100, 8'h55, 8'h55, 8'hAA, 1'b0, 4'b1001});
    vecs.push_back('{"add_ff_01",   3'b100, 8'hFF, 8'h01, 8'h00, 1'b0, 4'b0110});
    vecs.push_back('{"sub_aa_55",   3'b101, 8'hAA, 8'h55, 8'h55, 1'b0, 4'b0001});
    vecs.push_back('{"sub_00_01",   3'b101, 8'h00, 8'h01, 8'hFF, 1'b0, 4'b1010});
    vecs.push_back('{"rsv110",      3'b110, 8'h12, 8'h34, 8'h00, 1'b1, 4'b0100});
    vecs.push_back('{"add_7f_01",   3'b100, 8'h7F, 8'h01, 8'h80, 1'b0, 4'b1001});
    vecs.push_back('{"sub_80_01",   3'b101, 8'h80, 8'h01, 8'h7F, 1'b0, 4'b0001});
    vecs.push_back('{"rsv111",      3'b111, 8'hFF, 8'hFF, 8'h00, 1'b1, 4'b0100});
    vecs.push_back('{"sub_05_05",   3'b101, 8'h05, 8'h05, 8'h00, 1'b0, 4'b0100});
    vecs.push_back('{"add_03_04",   3'b100, 8'h03, 8'h04, 8'h07, 1'b0, 4'b0000});

    // Reset held two cycles with a request present: request must be dropped.
    i_rst_n = 1'b0;
    drive(1'b1, 3'b100, 8'h11, 8'h22);
    tick();
    tick();
    check_all("reset", 8'h00, 1'b0, 1'b0, 4'b0000);
    i_rst_n = 1'b1;

    // Back-to-back stream: each result must match the request of the prior edge.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      check_all(vecs[i].name, vecs[i].exp_out, 1'b1, vecs[i].exp_ill, vecs[i].exp_flags);
    end

    // Illegal result then idle with changing operands: everything holds, valid drops.
    drive(1'b1, 3'b110, 8'h12, 8'h34);
    tick();
    check_all("rsv_pulse", 8'h00, 1'b1, 1'b1, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'(k), 8'(8'h31 + k), 8'(8'h47 * (k + 1)));
      tick();
      check_all("rsv_hold", 8'h00, 1'b0, 1'b1, 4'b0100);
    end

    // Legal result then idle: out/flags hold, illegal stays clear.
    drive(1'b1, 3'b100, 8'h55, 8'h55);
    tick();
    check_all("add_pulse", 8'hAA, 1'b1, 1'b0, 4'b1001);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b101, 8'(k), 8'hF0);
      tick();
      check_all("add_hold", 8'hAA, 1'b0, 1'b0, 4'b1001);
    end

    // Mid-stream reset discards the in-flight result.
    drive(1'b1, 3'b000, 8'h0F, 8'hF0);
    tick();
    check_all("pre_rst", 8'hFF, 1'b1, 1'b0, 4'b1000);
    i_rst_n = 1'b0;
    drive(1'b1, 3'b100, 8'h01, 8'h02);
    tick();
    check_all("mid_rst", 8'h00, 1'b0, 1'b0, 4'b0000);
    i_rst_n = 1'b1;
    drive(1'b1, 3'b011, 8'h3C, 8'h0F);
    tick();
    check_all("post_rst", 8'h0C, 1'b1, 1'b0, 4'b0000);
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    tick();
    check_all("post_rst_idle", 8'h0C, 1'b0, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
